axi4_stream_pkt_defrag: RTL and testbench



---
 rtl/axi4_stream_defrag_pkg.sv | 34 +++
 rtl/axi4_stream_if.sv | 26 ++
 rtl/axi4_stream_byte_packer.sv | 67 ++++++
 rtl/axi4_stream_pkt_defrag.sv | 177 +++++++++++++++++
 tb/tb_axi4_stream_pkt_defrag.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_defrag_pkg.sv
// rtl/axi4_stream_defrag_pkg.sv - shared types and helpers for the stream defragmenter
// Purpose: FSM state type, width helpers and the tkeep popcount used by the
// defragmenter top and its byte packer.
package axi4_stream_defrag_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DROP  = 2'd2
  } state_e;

  // Widest tkeep the popcount helper handles (512-bit tdata).
  localparam int MAX_KEEP_W = 64;

  // Bytes per beat.
  function automatic int calc_bytes(input int data_width);
    return data_width / 8;
  endfunction

  // Bits needed to hold a per-beat byte count of 0..DATA_WIDTH_B.
  function automatic int calc_cnt_width(input int data_width);
    return $clog2(data_width / 8 + 1);
  endfunction

  function automatic int unsigned keep_popcount(input logic [MAX_KEEP_W-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle with master/slave modports
// Purpose: groups tdata/tkeep/tstrb/tvalid/tready/tlast/tid/tdest/tuser.
// master drives everything except tready; slave drives only tready.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/axi4_stream_byte_packer.sv
// rtl/axi4_stream_byte_packer.sv - two-word byte holding buffer with append and shift
// Purpose: appends wr_bytes_i low bytes of wr_data_i at byte offset lvl, and
// drops the low word when shift_i is set; packet agnostic.
// Ports: clk_i/rst_i, wr_en_i/wr_data_i/wr_bytes_i (append), shift_i (pop one
// word), clear_i (empty the buffer), word_o (low word), lvl_o (bytes held).
module axi4_stream_byte_packer
  import axi4_stream_defrag_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_en_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  input  logic [calc_cnt_width(DATA_WIDTH)-1:0] wr_bytes_i,
  input  logic                                shift_i,
  input  logic                                clear_i,
  output logic [DATA_WIDTH-1:0]               word_o,
  output logic [calc_cnt_width(DATA_WIDTH)+1:0] lvl_o
);
  localparam int DATA_WIDTH_B   = calc_bytes(DATA_WIDTH);
  localparam int BYTE_CNT_WIDTH = calc_cnt_width(DATA_WIDTH);
  localparam int LVLW           = BYTE_CNT_WIDTH + 2;
  localparam int BUF_B          = 2 * DATA_WIDTH_B;

  logic [2*DATA_WIDTH-1:0] buf_q, buf_d, base, ins, bit_mask;
  logic [LVLW-1:0]         lvl_q, lvl_d, lvl_base;
  logic [BUF_B-1:0]        byte_mask;

  always_comb begin
    // A same-cycle shift happens first, so the append lands after the
    // remaining bytes (lvl - DATA_WIDTH_B).
    base      = shift_i ? (buf_q >> DATA_WIDTH) : buf_q;
    lvl_base  = shift_i ? (lvl_q - LVLW'(DATA_WIDTH_B)) : lvl_q;
    byte_mask = ((BUF_B'(1) << wr_bytes_i) - BUF_B'(1)) << lvl_base;
    bit_mask  = '0;
    for (int i = 0; i < BUF_B; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
    end
    ins   = {{DATA_WIDTH{1'b0}}, wr_data_i} << {lvl_base, 3'b000};
    buf_d = base;
    lvl_d = lvl_base;
    if (wr_en_i) begin
      // Bytes beyond wr_bytes_i are masked so the buffer stays zero above lvl.
      buf_d = (base & ~bit_mask) | (ins & bit_mask);
      lvl_d = lvl_base + LVLW'(wr_bytes_i);
    end
    if (clear_i) begin
      buf_d = '0;
      lvl_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      lvl_q <= '0;
    end else begin
      buf_q <= buf_d;
      lvl_q <= lvl_d;
    end
  end

  assign word_o = buf_q[DATA_WIDTH-1:0];
  assign lvl_o  = lvl_q;

endmodule

// File: rtl/axi4_stream_pkt_defrag.sv
// rtl/axi4_stream_pkt_defrag.sv - rejoins stream fragments into packets with size limit
// Purpose: packs fragment bytes back together, regenerates tlast at the end of
// the final fragment, truncates packets above MAX_PKT_SIZE_B and drops the rest.
// Ports: clk_i/rst_i; pkt_i fragments (tuser[0] on tlast = final fragment);
// pkt_o packets (tuser[0] on tlast = truncated); pkt_cnt_o good packets;
// err_cnt_o truncated packets.
module axi4_stream_pkt_defrag
  import axi4_stream_defrag_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int MAX_PKT_SIZE_B = 9600,
  parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o,
  output logic [31:0]   pkt_cnt_o,
  output logic [31:0]   err_cnt_o
);
  localparam int DATA_WIDTH_B   = calc_bytes(DATA_WIDTH);
  localparam int BYTE_CNT_WIDTH = calc_cnt_width(DATA_WIDTH);
  localparam int LVLW           = BYTE_CNT_WIDTH + 2;
  localparam int PBW            = PKT_SIZE_WIDTH + 1;
  localparam int SUMW           = PKT_SIZE_WIDTH + 2;
  localparam int KW1            = DATA_WIDTH_B + 1;
  localparam logic [SUMW-1:0] MAX_V = SUMW'(MAX_PKT_SIZE_B);
  localparam logic [LVLW-1:0] DWB_V = LVLW'(DATA_WIDTH_B);

  state_e                state_q, state_d;
  logic [PBW-1:0]        pkt_bytes_q, pkt_bytes_d;
  logic                  err_q, err_d, drop_pend_q, drop_pend_d, first_q, first_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

  logic [LVLW-1:0]           lvl;
  logic [DATA_WIDTH-1:0]     buf_word;
  logic [BYTE_CNT_WIDTH-1:0] in_bytes;
  logic [MAX_KEEP_W-1:0]     keep_ext;
  logic [SUMW-1:0]           bytes_sum;
  logic [KW1-1:0]            keep_tmp;
  logic out_valid, out_last, out_fire, in_ready, in_fire, final_beat, oversize;
  logic wr_en, shift_en, clr_en;
  logic unused_in;

  axi4_stream_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en),
    .wr_data_i  (pkt_i.tdata),
    .wr_bytes_i (in_bytes),
    .shift_i    (shift_en),
    .clear_i    (clr_en),
    .word_o     (buf_word),
    .lvl_o      (lvl)
  );

  always_comb begin
    keep_ext = '0;
    keep_ext[DATA_WIDTH_B-1:0] = pkt_i.tkeep;
    in_bytes   = pkt_i.tlast ? BYTE_CNT_WIDTH'(keep_popcount(keep_ext))
                             : BYTE_CNT_WIDTH'(DATA_WIDTH_B);
    bytes_sum  = SUMW'(pkt_bytes_q) + SUMW'(in_bytes);
    oversize   = bytes_sum > MAX_V;
    final_beat = pkt_i.tlast && pkt_i.tuser[0];
    out_last   = (state_q == FLUSH) && (lvl <= DWB_V);
    // A full word is held back in ACCUM so tlast can still be attached to it;
    // an error with nothing buffered still emits one empty tlast beat.
    out_valid  = (lvl > DWB_V) || ((state_q == FLUSH) && ((lvl != '0) || err_q));
    out_fire   = out_valid && pkt_o.tready;
    case (state_q)
      ACCUM:   in_ready = (lvl <= DWB_V) || out_fire;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    in_fire  = pkt_i.tvalid && in_ready;
    wr_en    = in_fire && (state_q == ACCUM) && !oversize;
    shift_en = out_fire && !out_last;
    // The tlast beat may hold fewer than a word; empty the buffer outright.
    clr_en   = out_fire && out_last;
    keep_tmp = (KW1'(1) << lvl) - KW1'(1);
  end

  always_comb begin
    state_d     = state_q;
    pkt_bytes_d = pkt_bytes_q;
    err_d       = err_q;
    drop_pend_d = drop_pend_q;
    first_d     = first_q;
    tid_d       = tid_q;
    tdest_d     = tdest_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          if (first_q) begin
            tid_d   = pkt_i.tid;
            tdest_d = pkt_i.tdest;
            first_d = 1'b0;
          end
          if (oversize) begin
            err_d       = 1'b1;
            drop_pend_d = !final_beat;
            state_d     = FLUSH;
          end else begin
            pkt_bytes_d = PBW'(bytes_sum);
            if (final_beat) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if ((lvl == '0) && !err_q) begin
          // Empty packet: nothing to emit, nothing to count.
          state_d     = ACCUM;
          pkt_bytes_d = '0;
          first_d     = 1'b1;
        end else if (clr_en) begin
          if (err_q) err_cnt_d = err_cnt_q + 32'd1;
          else       pkt_cnt_d = pkt_cnt_q + 32'd1;
          pkt_bytes_d = '0;
          err_d       = 1'b0;
          drop_pend_d = 1'b0;
          first_d     = 1'b1;
          state_d     = drop_pend_q ? DROP : ACCUM;
        end
      end
      DROP: begin
        if (in_fire && final_beat) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ACCUM;
      pkt_bytes_q <= '0;
      err_q       <= 1'b0;
      drop_pend_q <= 1'b0;
      first_q     <= 1'b1;
      tid_q       <= '0;
      tdest_q     <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pkt_bytes_q <= pkt_bytes_d;
      err_q       <= err_d;
      drop_pend_q <= drop_pend_d;
      first_q     <= first_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pkt_i.tready = in_ready;
  assign pkt_o.tdata  = buf_word;
  assign pkt_o.tkeep  = out_last ? keep_tmp[DATA_WIDTH_B-1:0] : '1;
  assign pkt_o.tstrb  = pkt_o.tkeep;
  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tlast  = out_last;
  assign pkt_o.tid    = tid_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tuser  = USER_WIDTH'(out_last && err_q);
  assign pkt_cnt_o    = pkt_cnt_q;
  assign err_cnt_o    = err_cnt_q;

  assign unused_in = ^{pkt_i.tstrb, pkt_i.tuser, keep_tmp[DATA_WIDTH_B]};

endmodule

// File: tb/tb_axi4_stream_pkt_defrag.sv
// tb/tb_axi4_stream_pkt_defrag.sv - self-checking bench for axi4_stream_pkt_defrag
module tb_axi4_stream_pkt_defrag;
  localparam int MAX_B = 16;
  localparam int LIMIT = 1000;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] pkt_cnt, err_cnt;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) out_if ();

  axi4_stream_pkt_defrag #(
    .DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .MAX_PKT_SIZE_B(MAX_B)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pkt_i     (in_if),
    .pkt_o     (out_if),
    .pkt_cnt_o (pkt_cnt),
    .err_cnt_o (err_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        fin;
    logic        id;
  } ibeat_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
    logic        id;
  } obeat_t;

  ibeat_t in_q[$];
  obeat_t exp_q[$];
  int     frag_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     exp_pkts = 0;
  int     exp_errs = 0;
  logic [7:0] seq_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] keep_to_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Reference model: the packet is the byte stream of its fragments; beats are
  // accepted while the running total stays within MAX_B, the first beat that
  // would exceed it ends the packet as truncated. Output is that byte stream cut
  // into 4-byte words.
  task automatic add_packet(input bit rnd, input logic id);
    logic [7:0] acc[$];
    int cum;
    bit err;
    int nout;
    cum = 0;
    err = 1'b0;
    for (int f = 0; f < frag_q.size(); f++) begin
      int n;
      int nb;
      n  = frag_q[f];
      nb = (n == 0) ? 1 : (n + 3) / 4;
      for (int k = 0; k < nb; k++) begin
        ibeat_t b;
        int cnt;
        bit take;
        cnt  = (k == nb - 1) ? n - 4 * k : 4;
        take = !err && (cum + cnt <= MAX_B);
        if (!err && !take) err = 1'b1;
        if (take) cum += cnt;
        b.data = $urandom();
        for (int j = 0; j < cnt; j++) begin
          logic [7:0] v;
          if (rnd) v = 8'($urandom());
          else begin
            v = seq_byte;
            seq_byte++;
          end
          b.data[j*8 +: 8] = v;
          if (take) acc.push_back(v);
        end
        b.last = (k == nb - 1);
        b.keep = b.last ? 4'((1 << cnt) - 1) : 4'hf;
        b.fin  = b.last && (f == frag_q.size() - 1);
        b.id   = id;
        in_q.push_back(b);
      end
    end
    if (err || acc.size() > 0) begin
      nout = (acc.size() == 0) ? 1 : (acc.size() + 3) / 4;
      for (int j = 0; j < nout; j++) begin
        obeat_t o;
        int c;
        c = acc.size() - 4 * j;
        if (c > 4) c = 4;
        if (c < 0) c = 0;
        o.data = '0;
        for (int m = 0; m < c; m++) o.data[m*8 +: 8] = acc[4*j+m];
        o.last = (j == nout - 1);
        o.keep = o.last ? 4'((1 << c) - 1) : 4'hf;
        o.err  = o.last && err;
        o.id   = id;
        exp_q.push_back(o);
      end
      if (err) exp_errs++;
      else     exp_pkts++;
    end
    frag_q.delete();
  endtask

  task automatic drive_all(input int gap_pct);
    while (in_q.size() > 0) begin
      ibeat_t b;
      int wait_cnt;
      b = in_q.pop_front();
      @(negedge clk);
      while ($urandom_range(99) < gap_pct) begin
        in_if.tvalid = 1'b0;
        @(negedge clk);
      end
      in_if.tdata  = b.data;
      in_if.tkeep  = b.keep;
      in_if.tstrb  = 4'($urandom());
      in_if.tlast  = b.last;
      in_if.tuser  = b.fin;
      in_if.tid    = b.id;
      in_if.tdest  = ~b.id;
      in_if.tvalid = 1'b1;
      wait_cnt = 0;
      #1;
      while (!in_if.tready && wait_cnt < LIMIT) begin
        @(negedge clk);
        #1;
        wait_cnt++;
      end
      if (wait_cnt >= LIMIT) check("drv_stall", 32'(in_if.tready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_if.tvalid = 1'b0;
  endtask

  task automatic monitor(input int rdy_pct, input int n_exp);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n_exp && cyc < 20 * LIMIT) begin
      @(negedge clk);
      out_if.tready = ($urandom_range(99) < rdy_pct);
      #1;
      if (out_if.tvalid && out_if.tready) begin
        obeat_t e;
        logic [31:0] m;
        e = exp_q.pop_front();
        m = keep_to_mask(e.keep);
        check("out_data", out_if.tdata & m, e.data & m);
        check("out_ctl", 32'({out_if.tkeep, out_if.tlast, out_if.tuser[0], out_if.tid, out_if.tdest}),
              32'({e.keep, e.last, e.err, e.id, ~e.id}));
        got++;
      end
      cyc++;
    end
    check("out_beats", 32'(got), 32'(n_exp));
    out_if.tready = 1'b1;
  endtask

  task automatic run(input int gap_pct, input int rdy_pct);
    int n_exp;
    n_exp = exp_q.size();
    fork
      drive_all(gap_pct);
      monitor(rdy_pct, n_exp);
    join
    repeat (3) @(negedge clk);
    #1;
    check("idle_tvalid", 32'(out_if.tvalid), 32'd0);
    check("pkt_cnt", pkt_cnt, 32'(exp_pkts));
    check("err_cnt", err_cnt, 32'(exp_errs));
  endtask

  initial begin
    rst           = 1'b1;
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tstrb   = '0;
    in_if.tlast   = 1'b0;
    in_if.tuser   = '0;
    in_if.tid     = '0;
    in_if.tdest   = '0;
    out_if.tready = 1'b0;
    seq_byte      = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_tready", 32'(in_if.tready), 32'd1);
    check("rst_out_tvalid", 32'(out_if.tvalid), 32'd0);
    check("rst_pkt_cnt", pkt_cnt, 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);

    // single 10 B fragment
    frag_q = '{10};
    add_packet(1'b0, 1'b1);
    run(0, 100);

    // 6 B + 5 B, payload 0x00..0x0A
    seq_byte = 8'h00;
    frag_q = '{6, 5};
    add_packet(1'b0, 1'b0);
    run(0, 100);

    // same traffic under backpressure and input gaps
    for (int r = 0; r < 4; r++) begin
      seq_byte = 8'h00;
      frag_q = '{6, 5};
      add_packet(1'b0, 1'(r));
    end
    run(30, 50);

    // 24 B against a 16 B limit, then an intact 8 B packet
    frag_q = '{8, 8, 8};
    add_packet(1'b1, 1'b0);
    frag_q = '{8};
    add_packet(1'b1, 1'b1);
    run(0, 100);

    // exactly one word followed by an empty final tlast
    frag_q = '{4, 0};
    add_packet(1'b1, 1'b0);
    run(0, 100);

    // reset with 5 B buffered and the output stalled
    out_if.tready = 1'b0;
    frag_q = '{5};
    add_packet(1'b1, 1'b1);
    exp_q.delete();
    in_q[in_q.size()-1].fin = 1'b0;
    drive_all(0);
    #1;
    check("held_5b_tvalid", 32'(out_if.tvalid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pkts = 0;
    exp_errs = 0;
    #1;
    check("midrst_tvalid", 32'(out_if.tvalid), 32'd0);
    check("midrst_tready", 32'(in_if.tready), 32'd1);
    check("midrst_pkt_cnt", pkt_cnt, 32'd0);
    check("midrst_err_cnt", err_cnt, 32'd0);
    frag_q = '{7};
    add_packet(1'b1, 1'b0);
    run(0, 100);

    // random fragments, some past the size limit
    for (int p = 0; p < 30; p++) begin
      int nf;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) frag_q.push_back($urandom_range(0, 9));
      add_packet(1'b1, 1'($urandom()));
    end
    run(25, 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
